// File: rtl/md5_match_collector.sv
// Collects md5core candidates whose hash equals a loaded target into a small
// FIFO with a registered head, drained through a valid/ready port.
module md5_match_collector #(
  parameter int PIPE_DEPTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cand_valid,
  input  logic             target_load,
  input  logic [127:0]     target_hash,
  input  logic [127:0]     hash,
  input  logic [511:0]     message_in,
  output logic             match_valid,
  input  logic             match_ready,
  output logic [511:0]     match_message,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PIPE_DEPTH-1:0] slot_sr;
  logic [127:0]          target_q;
  logic [511:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           fifo_count;

  logic                  slot_valid;
  logic                  hit;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [AW:0]           count_nxt;
  logic                  head_from_input;

  // Match detection, FIFO handshake and next-pointer arithmetic.
  always_comb begin
    slot_valid      = slot_sr[PIPE_DEPTH-1];
    hit             = slot_valid && (hash == target_q);
    fifo_full       = (fifo_count == (AW+1)'(FIFO_DEPTH));
    match_valid     = (fifo_count != '0);
    pop             = match_valid && match_ready;
    push            = hit && (!fifo_full || pop);
    rd_ptr_nxt      = rd_ptr + AW'(pop);
    count_nxt       = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    // The new entry becomes the head when nothing older survives this edge.
    head_from_input = push && (fifo_count == (AW+1)'(pop));
    busy            = (|slot_sr) || match_valid;
  end

  // FIFO storage; contents behind the pointers need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= message_in;
  end

  // Control state: validity pipe, target, FIFO pointers, head register, status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_sr       <= '0;
      target_q      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      match_message <= '0;
      match_count   <= '0;
      overflow      <= 1'b0;
    end else begin
      slot_sr    <= {slot_sr[PIPE_DEPTH-2:0], cand_valid};
      if (target_load) target_q <= target_hash;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      // Head holds its last value once the FIFO drains empty.
      if (count_nxt != '0)
        match_message <= head_from_input ? message_in : mem[rd_ptr_nxt];
      if (hit && (match_count != '1))
        match_count <= match_count + CNT_W'(1);
      // A drop in the same cycle as a target load still leaves overflow set,
      // so a lost match is never silently hidden.
      if (hit && !push)
        overflow <= 1'b1;
      else if (target_load)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_md5_match_collector.sv
// Scoreboard bench: a queue-based model of md5core latency and the match
// FIFO predicts outputs; a negedge monitor compares against the DUT.
module tb_md5_match_collector;

  localparam int P  = 64;
  localparam int FD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, cand_valid, target_load, match_ready;
  logic [127:0]  target_hash, hash;
  logic [511:0]  message_in, match_message;
  logic          match_valid, overflow, busy;
  logic [CW-1:0] match_count;

  md5_match_collector #(.PIPE_DEPTH(P), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cand_valid(cand_valid), .target_load(target_load),
    .target_hash(target_hash), .hash(hash), .message_in(message_in),
    .match_valid(match_valid), .match_ready(match_ready),
    .match_message(match_message), .match_count(match_count),
    .overflow(overflow), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    logic [127:0] h;
    logic [511:0] m;
  } ent_t;

  int            checks   = 0;
  int            failures = 0;
  ent_t          pipe_q[$];
  logic [511:0]  exp_q[$];
  int            occ       = 0;
  logic [CW-1:0] m_cnt     = '0;
  bit            m_ovf     = 1'b0;
  logic [127:0]  m_tgt     = '0;
  int            cands_ago = P;
  bit            slot_v    = 1'b0;
  bit            just_rst  = 1'b0;
  bit            started   = 1'b0;
  logic [127:0]  cur_tgt   = '0;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply the rules for the edge that just passed, using the inputs held during that cycle.
  task automatic model_update();
    bit hit, pop, push;
    if (!rst_n) begin
      occ = 0; exp_q.delete(); m_cnt = '0; m_ovf = 1'b0; m_tgt = '0;
      cands_ago = P; just_rst = 1'b1;
      foreach (pipe_q[i]) pipe_q[i].v = 1'b0;
    end else begin
      hit  = slot_v && (hash == m_tgt);
      pop  = (occ > 0) && match_ready;
      push = hit && ((occ < FD) || pop);
      if (pop) occ--;
      if (push) begin occ++; exp_q.push_back(message_in); end
      if (hit && (m_cnt != {CW{1'b1}})) m_cnt++;
      if (hit && !push) m_ovf = 1'b1;
      else if (target_load) m_ovf = 1'b0;
      if (target_load) m_tgt = target_hash;
      if (cand_valid) cands_ago = 0;
      else if (cands_ago < P) cands_ago++;
    end
  endtask

  // One cycle: update the model, then drive this cycle's inputs and the md5core output.
  task automatic drive(input bit cv, input logic [127:0] ch, input logic [511:0] cm,
                       input bit tl, input logic [127:0] th, input bit rdy, input bit rn);
    ent_t e;
    @(posedge clk); #1;
    model_update();
    rst_n = rn; cand_valid = cv; target_load = tl; target_hash = th; match_ready = rdy;
    e.v = cv; e.h = ch; e.m = cm;
    pipe_q.push_back(e);
    if (pipe_q.size() > P) begin
      e = pipe_q.pop_front();
      hash = e.h; message_in = e.m; slot_v = e.v;
    end else begin
      hash = rand128(); message_in = rand512(); slot_v = 1'b0;
    end
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, rand128(), rand512(), 1'b0, '0, rdy, 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b0, rand128(), rand512(), 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [127:0] t);
    drive(1'b0, rand128(), rand512(), 1'b1, t, 1'b0, 1'b1);
    cur_tgt = t;
  endtask

  // Monitor: status every cycle, message order on every accepted pop.
  always @(negedge clk) begin
    if (started) begin
      chk("match_valid", match_valid, occ > 0);
      chk("match_count", match_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, (cands_ago < P) || (occ > 0));
      if (just_rst) begin
        chk("msg_after_reset", match_message, '0);
        just_rst = 1'b0;
      end
      if (rst_n && match_valid && match_ready) begin
        if (exp_q.size() == 0) chk("pop_without_expect", match_valid, 1'b0);
        else chk("match_message", match_message, exp_q.pop_front());
      end
    end
  end

  localparam logic [127:0] H_TEST = 128'h098f6bcd4621d373cade4e832627b4f6;

  initial begin
    logic [511:0] tmsg;
    logic [127:0] t, t2;
    bit cv, need_load, tl, rn;
    logic [127:0] th;
    tmsg = {32'h74657374, 8'h80, 408'b0, 64'h2000_0000_0000_0000};
    rst_n = 1'b0; cand_valid = 1'b0; target_load = 1'b0; target_hash = '0;
    match_ready = 1'b0; hash = '0; message_in = '0;
    repeat (3) begin do_reset(); started = 1'b1; end

    // Single "test" candidate: latency and content.
    load(H_TEST);
    drive(1'b1, H_TEST, tmsg, 1'b0, '0, 1'b0, 1'b1);
    repeat (P) idle(1'b0);
    @(negedge clk); chk("t1_not_early", match_valid, 1'b0);
    idle(1'b0);
    @(negedge clk);
    chk("t1_valid", match_valid, 1'b1);
    chk("t1_msg", match_message, tmsg);
    chk("t1_count", match_count, 16'd1);
    repeat (3) idle(1'b1);

    // Matching hash on invalid slots never counts.
    do_reset(); load(H_TEST);
    repeat (P + 10) drive(1'b0, H_TEST, rand512(), 1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_count", match_count, 16'd0);
    chk("t2_busy", busy, 1'b0);

    // Six back-to-back hits with no consumer: four kept, overflow sticky.
    do_reset(); t = rand128(); load(t);
    for (int j = 0; j < 6; j++) drive(1'b1, t, rand512(), 1'b0, '0, 1'b0, 1'b1);
    repeat (P + 3) idle(1'b0);
    @(negedge clk);
    chk("t3_count", match_count, 16'd6);
    chk("t3_overflow", overflow, 1'b1);
    repeat (5) idle(1'b1);
    @(negedge clk); chk("t3_drained", match_valid, 1'b0);

    // Full FIFO with pop and push in the same cycle.
    do_reset(); t = rand128(); load(t);
    for (int j = 0; j < P + 15; j++) begin
      cv = (j < 4) || (j == 10);
      drive(cv, cv ? t : rand128(), rand512(), 1'b0, '0, j == 10 + P, 1'b1);
    end
    @(negedge clk);
    chk("t4_overflow", overflow, 1'b0);
    chk("t4_count", match_count, 16'd5);
    repeat (6) idle(1'b1);
    @(negedge clk); chk("t4_drained", match_valid, 1'b0);

    // Reset with two queued and ten in flight discards everything.
    do_reset(); t = rand128(); load(t);
    for (int j = 0; j < P + 31; j++) begin
      cv = (j < 2) || (j >= 20 && j < 30);
      drive(cv, cv ? t : rand128(), rand512(), 1'b0, '0, 1'b0, j != P + 5);
    end
    repeat (P + 5) idle(1'b1);
    @(negedge clk);
    chk("t5_valid", match_valid, 1'b0);
    chk("t5_count", match_count, 16'd0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_msg", match_message, '0);

    // Retarget while an old-target match is in flight.
    do_reset(); t = rand128(); t2 = rand128(); load(t);
    for (int j = 0; j < P + 21; j++) begin
      cv = (j < 5) || (j == 10);
      drive(cv, cv ? t : rand128(), rand512(), j == P + 6, t2, 1'b0, 1'b1);
    end
    cur_tgt = t2;
    @(negedge clk);
    chk("t6_overflow", overflow, 1'b0);
    chk("t6_count", match_count, 16'd5);
    chk("t6_valid", match_valid, 1'b1);
    repeat (6) idle(1'b1);
    @(negedge clk); chk("t6_drained", match_valid, 1'b0);

    // Randomized traffic with occasional retargets and resets.
    need_load = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      cv = $urandom_range(0, 1) == 1;
      tl = need_load || ($urandom_range(0, 99) == 0);
      th = ($urandom_range(0, 1) == 1) ? rand128() : cur_tgt;
      rn = ($urandom_range(0, 299) != 0);
      drive(cv, ($urandom_range(0, 9) < 7) ? cur_tgt : rand128(), rand512(),
            tl, th, $urandom_range(0, 2) != 0, rn);
      if (tl) cur_tgt = th;
      need_load = !rn;
    end
    repeat (P + 10) idle(1'b1);
    @(negedge clk); chk("final_drained", match_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
